// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit holding the MIPS HI/LO registers.
// MUL/DIV take 33 edges from the issuing edge; MTHI/MTLO complete on their issuing edge.
// Optional feature macro: MDU_DIV_EN (defined = divider present; undefined = DIV/DIVU
// only pulse done for one cycle and leave hi/lo untouched).
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
`ifdef MDU_DIV_EN
    ,
    S_DIV  = 2'd3
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: product upper half / partial remainder; low: multiplier / dividend -> quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  // opnd: multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // qneg: negate product (MUL) or quotient (DIV) in FIX
  logic             qneg_q, qneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
`endif

  // Operand magnitudes for the signed variants (op[0]=0 means signed)
  logic             sgn_op, neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign sgn_op = ~op[0];
  assign neg_a  = sgn_op & a[WIDTH-1];
  assign neg_b  = sgn_op & b[WIDTH-1];
  assign abs_a  = neg_a ? -a : a;
  assign abs_b  = neg_b ? -b : b;

  // One shift-add step: add multiplicand when multiplier LSB is set, then shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

`ifdef MDU_DIV_EN
  // One restoring step: shift next dividend bit into the remainder, trial-subtract divisor
  logic [WIDTH:0] rem_sh, rem_diff;
  assign rem_sh   = {acc_q, low_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
`endif

  // Final sign fix of the 64-bit product
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  assign prod_raw = {acc_q, low_q};
  assign prod_fix = qneg_q ? -prod_raw : prod_raw;

  // Issue is possible from IDLE, and for MUL/DIV also on the completing FIX edge
  logic idle_c, issue_ok_c;
  assign idle_c     = (state_q == S_IDLE);
  assign issue_ok_c = idle_c || (state_q == S_FIX);

  // Next-state, datapath and output computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    low_d    = low_q;
    opnd_d   = opnd_q;
    qneg_d   = qneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
`endif

    case (state_q)
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        acc_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        low_d = {low_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
`endif
      S_FIX: begin
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hi_d = rneg_q ? -acc_q : acc_q;
          lo_d = div0_q ? {WIDTH{1'b1}} : (qneg_q ? -low_q : low_q);
        end else
`endif
        begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (start && issue_ok_c) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          acc_d    = '0;
          low_d    = abs_b;
          opnd_d   = abs_a;
          qneg_d   = neg_a ^ neg_b;
          cnt_d    = '0;
          state_d  = S_MUL;
`ifdef MDU_DIV_EN
          is_div_d = 1'b0;
`endif
        end
        OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
          acc_d    = '0;
          low_d    = abs_a;
          opnd_d   = abs_b;
          qneg_d   = neg_a ^ neg_b;
          rneg_d   = neg_a;
          div0_d   = (b == '0);
          is_div_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_DIV;
`else
          done_d   = 1'b1;
`endif
        end
        OP_MTHI: if (idle_c) hi_d = a;
        OP_MTLO: if (idle_c) lo_d = a;
        default: ;
      endcase
    end

    // busy rises one edge after an issue from IDLE, drops on the completing edge
    busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      opnd_q   <= '0;
      qneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      opnd_q   <= opnd_d;
      qneg_q   <= qneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
